// File: rtl/fifo_sync_ctrl.sv
// rtl/fifo_sync_ctrl.sv - single-clock FIFO controller sequencing a dual-port SRAM
// Extra-MSB binary pointers distinguish full from empty; all status decodes from registered pointers.
module fifo_sync_ctrl #(
    parameter int A_LENGTH  = 4,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_req,
    input  logic                rd_req,
    input  logic                flush,
    output logic                wr_en_out,
    output logic                rd_en_out,
    output logic [A_LENGTH-1:0] b_wr_ptr,
    output logic [A_LENGTH-1:0] b_rd_ptr,
    output logic                rd_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [A_LENGTH:0]   fifo_count,
    output logic                overflow,
    output logic                underflow
);

    localparam int PW = A_LENGTH + 1;
    localparam logic [A_LENGTH:0] AF_LVL = PW'(AF_THRESH);
    localparam logic [A_LENGTH:0] AE_LVL = PW'(AE_THRESH);

    logic [A_LENGTH:0] wr_ptr_q, wr_ptr_d;
    logic [A_LENGTH:0] rd_ptr_q, rd_ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    always_comb begin
        full         = (wr_ptr_q[A_LENGTH] != rd_ptr_q[A_LENGTH]) &&
                       (wr_ptr_q[A_LENGTH-1:0] == rd_ptr_q[A_LENGTH-1:0]);
        empty        = (wr_ptr_q == rd_ptr_q);
        fifo_count   = wr_ptr_q - rd_ptr_q;
        almost_full  = (fifo_count >= AF_LVL);
        almost_empty = (fifo_count <= AE_LVL);
        b_wr_ptr     = wr_ptr_q[A_LENGTH-1:0];
        b_rd_ptr     = rd_ptr_q[A_LENGTH-1:0];
        wr_en_out    = wr_req & ~full & ~flush;
        rd_en_out    = rd_req & ~empty & ~flush;
    end

    // Flush wins over everything: pointers clear and the flush cycle's requests never raise errors.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_valid_d  = rd_en_out;
        overflow_d  = wr_req & full & ~flush;
        underflow_d = rd_req & empty & ~flush;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rd_valid_d = 1'b0;
        end else begin
            if (wr_en_out) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en_out) rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb/tb_fifo_sync_ctrl.sv - self-checking bench for fifo_sync_ctrl
// Occupancy/queue reference model plus a behavioural SRAM stub for data-order checks.
module tb_fifo_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, wr_req, rd_req, flush;
    logic       wr_en_out, rd_en_out, rd_valid, full, empty, almost_full, almost_empty;
    logic       overflow, underflow;
    logic [3:0] b_wr_ptr, b_rd_ptr;
    logic [4:0] fifo_count;

    fifo_sync_ctrl #(.A_LENGTH(4), .AF_THRESH(14), .AE_THRESH(2)) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req), .flush(flush),
        .wr_en_out(wr_en_out), .rd_en_out(rd_en_out), .b_wr_ptr(b_wr_ptr), .b_rd_ptr(b_rd_ptr),
        .rd_valid(rd_valid), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .fifo_count(fifo_count), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    logic [7:0] rdata;
    logic [7:0] next_data;
    always @(posedge clk) begin
        if (wr_en_out) mem[b_wr_ptr] <= next_data;
        if (rd_en_out) rdata <= mem[b_rd_ptr];
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_count, m_wp, m_rp;
    logic       m_rv, m_ov, m_un, exp_wen, exp_ren, obs_wen, obs_ren;
    logic [7:0] m_rdata;
    logic [7:0] q[$];

    task automatic model_clear();
        m_count = 0; m_wp = 0; m_rp = 0;
        m_rv = 0; m_ov = 0; m_un = 0;
        q.delete();
        next_data = 8'd0;
    endtask

    // Drives one cycle of requests (from posedge+1), samples the enables at negedge, advances the model.
    task automatic step(input logic w, input logic r, input logic f);
        wr_req = w; rd_req = r; flush = f;
        exp_wen = w && (m_count != 16) && !f;
        exp_ren = r && (m_count != 0) && !f;
        @(negedge clk);
        obs_wen = wr_en_out;
        obs_ren = rd_en_out;
        @(posedge clk);
        #1;
        if (f) begin
            m_count = 0; m_wp = 0; m_rp = 0; m_rv = 0; m_ov = 0; m_un = 0;
            q.delete();
        end else begin
            m_ov = w && (m_count == 16);
            m_un = r && (m_count == 0);
            if (exp_wen) begin
                q.push_back(next_data);
                next_data = next_data + 8'd1;
                m_wp = (m_wp + 1) % 16;
            end
            if (exp_ren) begin
                m_rdata = q.pop_front();
                m_rp = (m_rp + 1) % 16;
            end
            m_count = m_count + int'(exp_wen) - int'(exp_ren);
            m_rv = exp_ren;
        end
        wr_req = 0; rd_req = 0; flush = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
        n_cmp++; if ({full, almost_full, rd_valid, overflow, underflow} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {full, almost_full, rd_valid, overflow, underflow}); end
        n_cmp++; if ({b_wr_ptr, b_rd_ptr} !== 8'h00) begin n_bad++; $display("FAIL reset_ptrs: got %h want 00", {b_wr_ptr, b_rd_ptr}); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0);
            n_cmp++; if (fifo_count !== 5'(i + 1)) begin n_bad++; $display("FAIL fill_count: got %0d want %0d", fifo_count, i + 1); end
            n_cmp++; if (almost_full !== (i + 1 >= 14)) begin n_bad++; $display("FAIL fill_af: got %b want %b at count %0d", almost_full, (i + 1 >= 14), i + 1); end
            n_cmp++; if (full !== (i + 1 == 16)) begin n_bad++; $display("FAIL fill_full: got %b want %b at count %0d", full, (i + 1 == 16), i + 1); end
        end
        step(1, 0, 0);
        n_cmp++; if (obs_wen !== 1'b0) begin n_bad++; $display("FAIL ovf_wen: got %b want 0", obs_wen); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
        n_cmp++; if (b_wr_ptr !== 4'd0) begin n_bad++; $display("FAIL ovf_wptr: got %0d want 0", b_wr_ptr); end
        step(0, 0, 0);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0);
            n_cmp++; if (obs_ren !== 1'b1) begin n_bad++; $display("FAIL drain_ren: got %b want 1", obs_ren); end
            n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL drain_rv: got %b want 1", rd_valid); end
            n_cmp++; if (rdata !== 8'(i)) begin n_bad++; $display("FAIL drain_data: got %0d want %0d", rdata, i); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty: got %b want 1", empty); end
        step(0, 1, 0);
        n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL unf_pulse: got %b want 1", underflow); end
        n_cmp++; if (b_rd_ptr !== 4'd0) begin n_bad++; $display("FAIL unf_rptr: got %0d want 0", b_rd_ptr); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL unf_rv: got %b want 0", rd_valid); end
        step(0, 0, 0);
        n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL unf_clear: got %b want 0", underflow); end
    endtask

    task automatic test_wrap();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 20; i++) begin
                step(i < 10, i >= 10, 0);
                n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL wrap_full: got %b want 0", full); end
                n_cmp++; if (fifo_count !== 5'(m_count)) begin n_bad++; $display("FAIL wrap_count: got %0d want %0d", fifo_count, m_count); end
                if (i >= 10) begin
                    n_cmp++; if (rdata !== m_rdata) begin n_bad++; $display("FAIL wrap_data: got %0d want %0d", rdata, m_rdata); end
                end
            end
        end
        n_cmp++; if (empty !== 1'b1 || fifo_count !== 5'd0) begin n_bad++; $display("FAIL wrap_end: got empty=%b count=%0d want 1/0", empty, fifo_count); end
        n_cmp++; if ({b_wr_ptr, b_rd_ptr} !== 8'h44) begin n_bad++; $display("FAIL wrap_ptrs: got %h want 44", {b_wr_ptr, b_rd_ptr}); end
    endtask

    task automatic test_simul();
        repeat (5) step(1, 0, 0);
        step(1, 1, 0);
        n_cmp++; if (fifo_count !== 5'd5) begin n_bad++; $display("FAIL sim5_count: got %0d want 5", fifo_count); end
        n_cmp++; if ({b_wr_ptr, b_rd_ptr} !== 8'hA5) begin n_bad++; $display("FAIL sim5_ptrs: got %h want a5", {b_wr_ptr, b_rd_ptr}); end
        repeat (11) step(1, 0, 0);
        step(1, 1, 0);
        n_cmp++; if ({obs_wen, obs_ren} !== 2'b01) begin n_bad++; $display("FAIL simfull_en: got %b want 01", {obs_wen, obs_ren}); end
        n_cmp++; if (fifo_count !== 5'd15) begin n_bad++; $display("FAIL simfull_count: got %0d want 15", fifo_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL simfull_ovf: got %b want 1", overflow); end
        repeat (15) step(0, 1, 0);
        step(1, 1, 0);
        n_cmp++; if ({obs_wen, obs_ren} !== 2'b10) begin n_bad++; $display("FAIL simempty_en: got %b want 10", {obs_wen, obs_ren}); end
        n_cmp++; if (fifo_count !== 5'd1) begin n_bad++; $display("FAIL simempty_count: got %0d want 1", fifo_count); end
        n_cmp++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL simempty_unf: got unf=%b rv=%b want 1/0", underflow, rd_valid); end
    endtask

    task automatic test_flush();
        repeat (8) step(1, 0, 0);
        step(1, 1, 0);
        n_cmp++; if (fifo_count !== 5'd9 || rd_valid !== 1'b1) begin n_bad++; $display("FAIL preflush: got count=%0d rv=%b want 9/1", fifo_count, rd_valid); end
        step(1, 1, 1);
        n_cmp++; if ({obs_wen, obs_ren} !== 2'b00) begin n_bad++; $display("FAIL flush_en: got %b want 00", {obs_wen, obs_ren}); end
        n_cmp++; if (fifo_count !== 5'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL flush_count: got count=%0d empty=%b want 0/1", fifo_count, empty); end
        n_cmp++; if ({rd_valid, overflow, underflow} !== 3'b000) begin n_bad++; $display("FAIL flush_pulses: got %b want 000", {rd_valid, overflow, underflow}); end
        n_cmp++; if ({b_wr_ptr, b_rd_ptr} !== 8'h00) begin n_bad++; $display("FAIL flush_ptrs: got %h want 00", {b_wr_ptr, b_rd_ptr}); end
    endtask

    task automatic test_random();
        logic w, r, f;
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 99) < ((i < 200) ? 75 : 35));
            r = ($urandom_range(0, 99) < ((i < 200) ? 35 : 75));
            f = ($urandom_range(0, 99) < 2);
            step(w, r, f);
            n_cmp++; if ({obs_wen, obs_ren} !== {exp_wen, exp_ren}) begin n_bad++; $display("FAIL rnd_en[%0d]: got %b want %b", i, {obs_wen, obs_ren}, {exp_wen, exp_ren}); end
            n_cmp++; if (fifo_count !== 5'(m_count)) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, fifo_count, m_count); end
            n_cmp++; if ({full, empty, almost_full, almost_empty} !== {m_count == 16, m_count == 0, m_count >= 14, m_count <= 2}) begin
                n_bad++; $display("FAIL rnd_flags[%0d]: got %b want %b", i, {full, empty, almost_full, almost_empty}, {m_count == 16, m_count == 0, m_count >= 14, m_count <= 2}); end
            n_cmp++; if ({b_wr_ptr, b_rd_ptr} !== {4'(m_wp), 4'(m_rp)}) begin n_bad++; $display("FAIL rnd_ptrs[%0d]: got %h want %h", i, {b_wr_ptr, b_rd_ptr}, {4'(m_wp), 4'(m_rp)}); end
            n_cmp++; if ({rd_valid, overflow, underflow} !== {m_rv, m_ov, m_un}) begin n_bad++; $display("FAIL rnd_pulses[%0d]: got %b want %b", i, {rd_valid, overflow, underflow}, {m_rv, m_ov, m_un}); end
            if (m_rv) begin
                n_cmp++; if (rdata !== m_rdata) begin n_bad++; $display("FAIL rnd_data[%0d]: got %0d want %0d", i, rdata, m_rdata); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        repeat (6) step(1, 0, 0);
        step(1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (fifo_count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin n_bad++; $display("FAIL midrst_status: got count=%0d empty=%b ae=%b want 0/1/1", fifo_count, empty, almost_empty); end
        n_cmp++; if ({b_wr_ptr, b_rd_ptr} !== 8'h00 || rd_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_ptrs: got ptrs=%h rv=%b want 00/0", {b_wr_ptr, b_rd_ptr}, rd_valid); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 0);
        n_cmp++; if (fifo_count !== 5'd1 || b_wr_ptr !== 4'd1) begin n_bad++; $display("FAIL postrst_write: got count=%0d wptr=%0d want 1/1", fifo_count, b_wr_ptr); end
    endtask

    initial begin
        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0;
        model_clear();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
